midi_poly_synth: RTL and testbench

Polyphonic successor to the single-voice MIDI square-wave synth. Consumes raw MIDI bytes from the UART receiver and parses Note On/Off with running status and channel filtering. Allocates notes to VOICES independent square-wave oscillators covering all 128 MIDI notes, and drives per-voice and OR-mixed buzz outputs. Sits between uart and the buzzer pins in top.

---
 rtl/midi_poly_synth_pkg.sv | 50 +++++
 rtl/midi_poly_synth_if.sv | 10 +
 rtl/midi_poly_synth_square_voice.sv | 53 +++++
 rtl/midi_poly_synth.sv | 185 ++++++++++++++++++
 tb/tb_midi_poly_synth.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/midi_poly_synth_pkg.sv
// Shared definitions for the polyphonic MIDI synth: status nibbles,
// parser states and the note-to-period lookup.
package midi_pkg;

  localparam logic [3:0] NOTE_OFF     = 4'h8;
  localparam logic [3:0] NOTE_ON      = 4'h9;
  localparam logic [7:0] REALTIME_MIN = 8'hF8;
  localparam int         REF_OCTAVE   = 4;

  typedef enum logic [1:0] {
    IDLE,
    NOTE,
    VEL
  } parse_state_e;

  // Periods in 12 MHz clocks for the reference octave (notes 48..59)
  function automatic logic [16:0] basePeriod(input logic [3:0] idx);
    case (idx)
      4'd0:    basePeriod = 17'd91736;
      4'd1:    basePeriod = 17'd86587;
      4'd2:    basePeriod = 17'd81728;
      4'd3:    basePeriod = 17'd77141;
      4'd4:    basePeriod = 17'd72811;
      4'd5:    basePeriod = 17'd68724;
      4'd6:    basePeriod = 17'd64867;
      4'd7:    basePeriod = 17'd61227;
      4'd8:    basePeriod = 17'd57790;
      4'd9:    basePeriod = 17'd54547;
      4'd10:   basePeriod = 17'd51485;
      4'd11:   basePeriod = 17'd48596;
      default: basePeriod = 17'd0;
    endcase
  endfunction

  // Octaves below the reference double the period, octaves above halve it
  function automatic logic [31:0] notePeriod(input logic [6:0] note);
    logic [3:0]  oct;
    logic [3:0]  idx;
    logic [31:0] base;
    oct  = 4'(note / 7'd12);
    idx  = 4'(note % 7'd12);
    base = {15'd0, basePeriod(idx)};
    if (oct < 4'(REF_OCTAVE)) begin
      notePeriod = base << (4'(REF_OCTAVE) - oct);
    end else begin
      notePeriod = base >> (oct - 4'(REF_OCTAVE));
    end
  endfunction

endpackage

// File: rtl/midi_poly_synth_if.sv
// Byte stream from the UART receiver into the synth.
interface midi_poly_synth_if;

  logic       rx_valid;
  logic [7:0] rx_byte;

  modport master (output rx_valid, output rx_byte);
  modport slave  (input  rx_valid, input  rx_byte);

endinterface

// File: rtl/midi_poly_synth_square_voice.sv
// One square-wave oscillator voice: gate, free-running counter and duty compare.
module square_voice #(
  parameter int CNT_W      = 25,
  parameter int DUTY_SHIFT = 2
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic             load_i,
  input  logic             release_i,
  input  logic [CNT_W-1:0] period_i,
  output logic             gate_o,
  output logic             buzz_o
);

  logic             gate_q, gate_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;

  // A load restarts the waveform from the top of its high phase and takes
  // priority over the counter wrap; a release parks the counter at zero.
  always_comb begin
    gate_d   = gate_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    if (load_i) begin
      gate_d   = 1'b1;
      cnt_d    = '0;
      period_d = period_i;
    end else if (release_i) begin
      gate_d = 1'b0;
      cnt_d  = '0;
    end else if (gate_q) begin
      cnt_d = (cnt_q == period_q - CNT_W'(1)) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Voice state register, cleared asynchronously
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      gate_q   <= 1'b0;
      cnt_q    <= '0;
      period_q <= '0;
    end else begin
      gate_q   <= gate_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
    end
  end

  assign gate_o = gate_q;
  assign buzz_o = gate_q && (cnt_q < (period_q >> DUTY_SHIFT));

endmodule

// File: rtl/midi_poly_synth.sv
// Polyphonic MIDI square-wave synth: byte parser with running status,
// voice allocator with retrigger/free/steal priority, and VOICES oscillators.
module midi_poly_synth
  import midi_pkg::*;
#(
  parameter int VOICES     = 4,
  parameter int CHANNEL    = 0,
  parameter int CNT_W      = 25,
  parameter int DUTY_SHIFT = 2
) (
  input  logic                  clk,
  input  logic                  resetq,
  midi_poly_synth_if.slave      rx,
  output logic                  buzz,
  output logic [VOICES-1:0]     voice_buzz,
  output logic [VOICES-1:0]     voice_gate,
  output logic [7*VOICES-1:0]   voice_note
);

  localparam int         PTR_W    = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam logic [3:0] CHAN_NIB = 4'(CHANNEL);
  localparam bit         OMNI     = (CHANNEL == 16);

  parse_state_e state_q, state_d;
  logic         statusOn_q, statusOn_d;
  logic [6:0]   noteLatch_q, noteLatch_d;
  logic         cmdValid_q, cmdValid_d;
  logic         cmdOn_q, cmdOn_d;
  logic [6:0]   cmdNote_q, cmdNote_d;

  logic [3:0]   statusHi;
  logic         chanMatch;

  logic [6:0]        note_q [VOICES];
  logic [6:0]        note_d [VOICES];
  logic [PTR_W-1:0]  stealPtr_q, stealPtr_d;
  logic [VOICES-1:0] loadVec;
  logic [VOICES-1:0] releaseVec;
  logic [CNT_W-1:0]  loadPeriod;

  assign statusHi  = rx.rx_byte[7:4];
  assign chanMatch = OMNI || (rx.rx_byte[3:0] == CHAN_NIB);

  // Parser: realtime bytes pass through untouched, note status bytes arm
  // running status, any other status drops it, and every completed
  // note/velocity pair becomes a one-cycle command.
  always_comb begin
    state_d     = state_q;
    statusOn_d  = statusOn_q;
    noteLatch_d = noteLatch_q;
    cmdValid_d  = 1'b0;
    cmdOn_d     = cmdOn_q;
    cmdNote_d   = cmdNote_q;
    if (rx.rx_valid) begin
      if (rx.rx_byte >= REALTIME_MIN) begin
        state_d = state_q;
      end else if (rx.rx_byte[7]) begin
        if (((statusHi == NOTE_OFF) || (statusHi == NOTE_ON)) && chanMatch) begin
          state_d    = NOTE;
          statusOn_d = (statusHi == NOTE_ON);
        end else begin
          state_d    = IDLE;
          statusOn_d = 1'b0;
        end
      end else begin
        case (state_q)
          NOTE: begin
            noteLatch_d = rx.rx_byte[6:0];
            state_d     = VEL;
          end
          VEL: begin
            cmdValid_d = 1'b1;
            cmdOn_d    = statusOn_q && (rx.rx_byte[6:0] != 7'd0);
            cmdNote_d  = noteLatch_q;
            state_d    = NOTE;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // Parser and command registers
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state_q     <= IDLE;
      statusOn_q  <= 1'b0;
      noteLatch_q <= 7'd0;
      cmdValid_q  <= 1'b0;
      cmdOn_q     <= 1'b0;
      cmdNote_q   <= 7'd0;
    end else begin
      state_q     <= state_d;
      statusOn_q  <= statusOn_d;
      noteLatch_q <= noteLatch_d;
      cmdValid_q  <= cmdValid_d;
      cmdOn_q     <= cmdOn_d;
      cmdNote_q   <= cmdNote_d;
    end
  end

  // Allocator: a note-on retriggers a voice already sounding that note,
  // else takes the lowest idle voice, else steals round-robin. A note-off
  // silences every voice sounding that note. Loops run high-to-low so the
  // lowest matching index is the one that sticks.
  always_comb begin
    logic             hitFound, freeFound;
    logic [PTR_W-1:0] hitIdx, freeIdx, target;
    hitFound   = 1'b0;
    freeFound  = 1'b0;
    hitIdx     = '0;
    freeIdx    = '0;
    target     = '0;
    loadVec    = '0;
    releaseVec = '0;
    stealPtr_d = stealPtr_q;
    note_d     = note_q;
    for (int v = VOICES - 1; v >= 0; v--) begin
      if (voice_gate[v] && (note_q[v] == cmdNote_q)) begin
        hitFound = 1'b1;
        hitIdx   = PTR_W'(v);
      end
      if (!voice_gate[v]) begin
        freeFound = 1'b1;
        freeIdx   = PTR_W'(v);
      end
    end
    if (cmdValid_q) begin
      if (cmdOn_q) begin
        if (hitFound) begin
          target = hitIdx;
        end else if (freeFound) begin
          target = freeIdx;
        end else begin
          target     = stealPtr_q;
          stealPtr_d = (stealPtr_q == PTR_W'(VOICES - 1)) ? '0 : stealPtr_q + PTR_W'(1);
        end
        loadVec[target] = 1'b1;
        note_d[target]  = cmdNote_q;
      end else begin
        for (int v = 0; v < VOICES; v++) begin
          if (voice_gate[v] && (note_q[v] == cmdNote_q)) begin
            releaseVec[v] = 1'b1;
          end
        end
      end
    end
  end

  // Per-voice note memory and steal pointer
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      stealPtr_q <= '0;
      for (int v = 0; v < VOICES; v++) begin
        note_q[v] <= 7'd0;
      end
    end else begin
      stealPtr_q <= stealPtr_d;
      for (int v = 0; v < VOICES; v++) begin
        note_q[v] <= note_d[v];
      end
    end
  end

  assign loadPeriod = CNT_W'(notePeriod(cmdNote_q));

  for (genvar g = 0; g < VOICES; g++) begin : gVoice
    square_voice #(
      .CNT_W      (CNT_W),
      .DUTY_SHIFT (DUTY_SHIFT)
    ) uVoice (
      .clk       (clk),
      .resetq    (resetq),
      .load_i    (loadVec[g]),
      .release_i (releaseVec[g]),
      .period_i  (loadPeriod),
      .gate_o    (voice_gate[g]),
      .buzz_o    (voice_buzz[g])
    );
    assign voice_note[7*g +: 7] = note_q[g];
  end

  assign buzz = |voice_buzz;

endmodule

// File: tb/tb_midi_poly_synth.sv
// Randomised and directed bench for midi_poly_synth against a note-level model.
module tb_midi_poly_synth;

  localparam int VOICES = 4;
  localparam int BASE_TBL [12] = '{91736, 86587, 81728, 77141, 72811, 68724,
                                   64867, 61227, 57790, 54547, 51485, 48596};

  logic                clk = 1'b0;
  logic                resetq;
  logic                buzz;
  logic [VOICES-1:0]   voiceBuzz;
  logic [VOICES-1:0]   voiceGate;
  logic [7*VOICES-1:0] voiceNote;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: per-voice sounding flag, note, period and cycle of last (re)start
  int mGate [VOICES];
  int mNote [VOICES];
  int mPer  [VOICES];
  int mLoad [VOICES];
  int mSteal;
  int mRun;
  int mHeld;
  bit pendValid;
  bit pendOn;
  int pendNote;

  midi_poly_synth_if rxIf ();

  midi_poly_synth #(
    .VOICES     (VOICES),
    .CHANNEL    (0),
    .CNT_W      (25),
    .DUTY_SHIFT (2)
  ) dut (
    .clk        (clk),
    .resetq     (resetq),
    .rx         (rxIf),
    .buzz       (buzz),
    .voice_buzz (voiceBuzz),
    .voice_gate (voiceGate),
    .voice_note (voiceNote)
  );

  // 100 MHz-scale clock; real timing does not matter to the bench
  always #5 clk = ~clk;

  // Rising-edge counter used as the model's time base
  always @(posedge clk) cyc <= cyc + 1;

  // Abort if the bench ever stops making progress
  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: time limit reached, required finish before 5ms");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int refPeriod(input int n);
    int oct;
    int idx;
    oct = n / 12;
    idx = n % 12;
    if (oct < 4) return BASE_TBL[idx] << (4 - oct);
    return BASE_TBL[idx] >> (oct - 4);
  endfunction

  task automatic modelReset();
    for (int v = 0; v < VOICES; v++) begin
      mGate[v] = 0;
      mNote[v] = 0;
      mPer[v]  = 1;
      mLoad[v] = 0;
    end
    mSteal    = 0;
    mRun      = -1;
    mHeld     = -1;
    pendValid = 0;
  endtask

  task automatic modelApply();
    int t;
    t = -1;
    if (pendOn) begin
      for (int v = 0; v < VOICES; v++) if (t < 0 && mGate[v] != 0 && mNote[v] == pendNote) t = v;
      for (int v = 0; v < VOICES; v++) if (t < 0 && mGate[v] == 0) t = v;
      if (t < 0) begin
        t = mSteal;
        mSteal = (mSteal + 1) % VOICES;
      end
      mGate[t] = 1;
      mNote[t] = pendNote;
      mPer[t]  = refPeriod(pendNote);
      mLoad[t] = cyc;
    end else begin
      for (int v = 0; v < VOICES; v++) if (mGate[v] != 0 && mNote[v] == pendNote) mGate[v] = 0;
    end
  endtask

  task automatic modelParse(input int b);
    if (b >= 248) return;
    if (b >= 128) begin
      if (((b >> 4) == 8 || (b >> 4) == 9) && (b % 16) == 0) begin
        mRun  = ((b >> 4) == 9) ? 1 : 0;
        mHeld = -1;
      end else begin
        mRun  = -1;
        mHeld = -1;
      end
      return;
    end
    if (mRun < 0) return;
    if (mHeld < 0) begin
      mHeld = b;
    end else begin
      pendValid = 1;
      pendOn    = (mRun == 1) && (b != 0);
      pendNote  = mHeld;
      mHeld     = -1;
    end
  endtask

  // Advance to the next falling edge, committing any command the DUT just applied
  task automatic stepNeg();
    @(negedge clk);
    if (pendValid) begin
      modelApply();
      pendValid = 0;
    end
  endtask

  task automatic applyStimulus(input int b);
    rxIf.rx_valid = 1'b1;
    rxIf.rx_byte  = 8'(b);
    stepNeg();
    rxIf.rx_valid = 1'b0;
    modelParse(b);
  endtask

  task automatic waitTo(input int target);
    while (cyc < target) stepNeg();
  endtask

  task automatic checkAll(input string tag);
    logic [VOICES-1:0]   expGate;
    logic [VOICES-1:0]   expBuzz;
    logic [7*VOICES-1:0] expNote;
    logic [7*VOICES-1:0] mask;
    for (int v = 0; v < VOICES; v++) begin
      expGate[v]       = (mGate[v] != 0);
      expBuzz[v]       = (mGate[v] != 0) && (((cyc - mLoad[v]) % mPer[v]) < (mPer[v] >> 2));
      expNote[7*v +: 7] = 7'(mNote[v]);
      mask[7*v +: 7]    = (mGate[v] != 0) ? 7'h7F : 7'h00;
    end
    checkOutput({tag, ".gate"}, 32'(voiceGate), 32'(expGate));
    checkOutput({tag, ".note"}, 32'(voiceNote & mask), 32'(expNote & mask));
    checkOutput({tag, ".vbuzz"}, 32'(voiceBuzz), 32'(expBuzz));
    checkOutput({tag, ".buzz"}, 32'(buzz), 32'(|expBuzz));
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic pulseReset(input string tag);
    #1 resetq = 1'b0;
    #2;
    checkOutput({tag, ".rstGate"}, 32'(voiceGate), 32'h0);
    checkOutput({tag, ".rstNote"}, 32'(voiceNote), 32'h0);
    checkOutput({tag, ".rstBuzz"}, 32'(buzz), 32'h0);
    checkOutput({tag, ".rstVbuzz"}, 32'(voiceBuzz), 32'h0);
    modelReset();
    resetq = 1'b1;
    stepNeg();
  endtask

  initial begin
    int load;
    int b;
    resetq        = 1'b1;
    rxIf.rx_valid = 1'b0;
    rxIf.rx_byte  = 8'h00;
    modelReset();
    #1 resetq = 1'b0;
    #2;
    checkOutput("reset.gate", 32'(voiceGate), 32'h0);
    checkOutput("reset.note", 32'(voiceNote), 32'h0);
    checkOutput("reset.buzz", 32'(buzz), 32'h0);
    checkOutput("reset.vbuzz", 32'(voiceBuzz), 32'h0);
    repeat (2) @(negedge clk);
    resetq = 1'b1;
    stepNeg();

    // Single note A4: period 27273, high for 6818 clocks
    applyStimulus(8'h90); applyStimulus(69); applyStimulus(100);
    stepNeg();
    load = mLoad[0];
    checkAll("a4.start");
    checkOutput("a4.note0", 32'(voiceNote[6:0]), 32'd69);
    checkOutput("a4.gate0", 32'(voiceGate), 32'h1);
    waitTo(load + 6817);
    checkOutput("a4.lastHigh", 32'(voiceBuzz[0]), 32'h1);
    checkAll("a4.lastHigh");
    waitTo(load + 6818);
    checkOutput("a4.firstLow", 32'(voiceBuzz[0]), 32'h0);
    waitTo(load + 27272);
    checkOutput("a4.beforeWrap", 32'(voiceBuzz[0]), 32'h0);
    waitTo(load + 27273);
    checkOutput("a4.afterWrap", 32'(voiceBuzz[0]), 32'h1);
    checkAll("a4.afterWrap");

    // Running status, velocity-zero note-off
    pulseReset("rs");
    foreach (BASE_TBL[i]) begin end
    applyStimulus(8'h90); applyStimulus(60); applyStimulus(64);
    applyStimulus(64); applyStimulus(64); applyStimulus(67); applyStimulus(0);
    stepNeg();
    checkOutput("rs.gates", 32'(voiceGate), 32'h3);
    checkOutput("rs.notes", 32'(voiceNote[13:0]), 32'((64 << 7) | 60));
    checkAll("rs.held");
    applyStimulus(60); applyStimulus(0);
    stepNeg();
    checkOutput("rs.off60", 32'(voiceGate), 32'h2);
    checkAll("rs.off60");

    // Voice stealing
    pulseReset("steal");
    applyStimulus(8'h90);
    for (int n = 60; n <= 64; n++) begin
      applyStimulus(n); applyStimulus(100);
    end
    stepNeg();
    checkOutput("steal.first", 32'(voiceNote), 32'((63 << 21) | (62 << 14) | (61 << 7) | 64));
    checkAll("steal.first");
    applyStimulus(65); applyStimulus(100);
    stepNeg();
    checkOutput("steal.second", 32'(voiceNote), 32'((63 << 21) | (62 << 14) | (65 << 7) | 64));
    checkAll("steal.second");

    // Realtime bytes interleaved with a note; C4 period 45868
    pulseReset("rt");
    applyStimulus(8'h90); applyStimulus(8'hF8); applyStimulus(60);
    applyStimulus(8'hFE); applyStimulus(100);
    stepNeg();
    load = mLoad[0];
    checkOutput("rt.gate", 32'(voiceGate), 32'h1);
    checkOutput("rt.note", 32'(voiceNote[6:0]), 32'd60);
    waitTo(load + 11466);
    checkOutput("rt.lastHigh", 32'(voiceBuzz[0]), 32'h1);
    waitTo(load + 11467);
    checkOutput("rt.firstLow", 32'(voiceBuzz[0]), 32'h0);
    checkAll("rt.end");

    // Channel filter and controller bytes
    pulseReset("chan");
    applyStimulus(8'h91); applyStimulus(60); applyStimulus(100);
    stepNeg();
    checkOutput("chan.other", 32'(voiceGate), 32'h0);
    applyStimulus(8'hB0); applyStimulus(7); applyStimulus(100);
    applyStimulus(8'h80); applyStimulus(60); applyStimulus(0);
    stepNeg();
    checkOutput("chan.cc", 32'(voiceGate), 32'h0);
    checkAll("chan.cc");

    // Reset mid-note, then the lowest note
    pulseReset("mid0");
    applyStimulus(8'h90); applyStimulus(70); applyStimulus(100);
    repeat (10) stepNeg();
    checkAll("mid.sounding");
    pulseReset("mid");
    applyStimulus(8'h90); applyStimulus(0); applyStimulus(1);
    stepNeg();
    checkOutput("low.gate", 32'(voiceGate), 32'h1);
    checkOutput("low.buzz", 32'(buzz), 32'h1);
    repeat (100) stepNeg();
    checkAll("low.run");
    checkOutput("low.period", 32'(mPer[0]), 32'd1467776);

    // Random byte soup over a small note pool to exercise retrigger and steal
    pulseReset("rnd");
    applyStimulus(8'h90);
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      case (r)
        0: begin
          case ($urandom_range(0, 6))
            0: b = 8'h90;
            1: b = 8'h80;
            2: b = 8'h91;
            3: b = 8'hB0;
            4: b = 8'hF0;
            5: b = 8'hF8;
            default: b = 8'h90;
          endcase
        end
        1, 2: b = int'($urandom_range(0, 2));
        default: b = 100 + int'($urandom_range(0, 7));
      endcase
      applyStimulus(b);
      repeat ($urandom_range(0, 3)) stepNeg();
      stepNeg();
      checkAll("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
